histo_readout_seq: RTL
======================

# histo_readout_seq

Streams the trigger-board monitoring histograms out of the `clk_adc` domain as a byte stream. It sits directly downstream of the trigger/coincidence block:
- it steps that block's `histostosend` channel index through all 16 input channels;
- it waits for that block's registered `histosout` words to settle, then captures them;
- it serialises the selected histograms, MSB first, over a valid/ready byte interface to the command/transmit path.

## Interface
Parameters:
- NCH, 16, number of input channels stepped through (index 0..NCH-1)
- NHIST, 8, number of 32-bit histogram words presented per channel
- SETTLE, 3, clk_adc cycles between driving a new `histostosend` and sampling `histosin`; range 1..15

Ports:
- clk_adc  in  1  single clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin a dump; ignored while busy
- hist_mask  in  8  bit h enables histogram h in the dump; sampled on accepted start
- histosin  in  NHIST*32  histogram words for the current index, flattened; word h at bits [32h+31:32h]
- histostosend  out  8  channel index driven to the trigger block
- tx_data  out  8  stream byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  consumer accepts byte when tx_valid && tx_ready
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at end of dump

## Operation
States, in order: IDLE → HDR → SELECT → CAPTURE → SEND → (NEXT) → CKSUM → FIN → IDLE.

- **IDLE:** start=1 latches hist_mask into mask_r, sets ch=0, clears checksum, and goes to HDR.
- **HDR:** tx_valid=1, tx_data=0xA5. On handshake, go to SELECT.
- **SELECT:**
  - histostosend=ch.
  - The settle counter loads SETTLE on entry and counts down.
  - At 0, go to CAPTURE.
- **CAPTURE:** latch all NHIST words of histosin into an internal buffer (one cycle); h=first set bit of mask_r.
  - If mask_r=0, skip to CKSUM; no channel stepping occurs.
- **SEND:**
  - Present buffer word h as 4 bytes: [31:24], [23:16], [15:8], [7:0].
  - Each handshake adds the byte to an 8-bit running sum (mod 256) and advances the byte index.
  - After byte 3, h advances to the next set bit of mask_r.
  - When no set bits remain, go to NEXT.
- **NEXT:** if ch=NCH-1, go to CKSUM. Otherwise ch=ch+1 and go to SELECT.
- **CKSUM:** present the checksum byte, or skip straight to FIN (see Configuration).
- **FIN:** done=1 for one cycle; busy falls in the same cycle; return to IDLE.

Stream length: 1 + NCH·4·popcount(mask) data bytes, plus 1 checksum byte if enabled. The header is not included in the checksum.

## Timing
- **Reset values:** histostosend=0, tx_data=0, tx_valid=0, busy=0, done=0; state IDLE.
- **Start:** start accepted at cycle T gives busy=1 and tx_valid=1 with 0xA5 at T+1.
- **Header to first data byte:**
  - Header handshake at cycle H.
  - histostosend=0 at H+1.
  - CAPTURE at H+1+SETTLE.
  - First data byte valid at H+2+SETTLE.
- **Handshake rules:**
  - tx_data and tx_valid are held stable while tx_valid && !tx_ready.
  - tx_valid never drops without a handshake, except on rst.
  - At most one byte is transferred per cycle.
  - With tx_ready held high, consecutive bytes of a channel go out on consecutive cycles.
- **histostosend:** changes only on SELECT entry. After the dump it holds NCH-1 until the next start or rst.
- **start while busy:** ignored; it is not queued.
- **start in the FIN cycle:** ignored. A start in the first IDLE cycle after FIN is accepted.
- **rst mid-dump:** takes effect the next cycle. Stream aborted, tx_valid=0, all outputs return to reset values, no done pulse.
- **hist_mask changes during a dump:** no effect.
- **Arithmetic:**
  - checksum 8-bit wrap-around.
  - ch 8-bit, compared against NCH-1.
  - settle counter 4-bit.

## Configuration
- HISTO_READOUT_CKSUM_EN defined:
  - CKSUM presents tx_data=the running sum, with tx_valid=1 until handshake, then FIN.
- HISTO_READOUT_CKSUM_EN undefined:
  - CKSUM passes straight to FIN in one cycle with tx_valid=0.
  - No checksum byte is sent.
  - The sum logic is not synthesised.

## Test plan
- **Single-histogram dump:** rst, hist_mask=0x01, histosin word0=0x11223344+ch for ch 0..15, tx_ready=1, pulse start.
  - Required: 0xA5, then per ch 0x11,0x22,0x33,0x44+ch, then checksum (if EN).
  - 65 (+1) bytes, done once, busy low after.
- **Settle latency:** hist_mask=0x80, SETTLE=3, word7 changes 2 cycles after histostosend.
  - Required: captured value is the settled value; first data byte valid exactly 5 cycles after the header handshake.
- **Backpressure:** hist_mask=0x05, tx_ready toggled pseudo-randomly.
  - Required: no byte lost or duplicated; tx_data stable while stalled; byte count 129 (+1).
- **Empty mask:** hist_mask=0x00, start.
  - Required: 0xA5 then 0x00 checksum (EN) or 0xA5 only; histostosend stays 0; done pulses.
- **Abort and restart:** rst asserted during ch 7 of a dump.
  - Required: tx_valid=0 and busy=0 next cycle; no done.
  - A fresh start then produces a complete, correct stream from ch 0.
- **Ignored start:** start re-pulsed while busy and in the FIN cycle.
  - Required: exactly one stream and one done.

Source files
------------

// File: rtl/histo_readout_seq.sv
// histo_readout_seq
//
// Purpose: dumps the trigger-board monitoring histograms as a byte stream.
// The sequencer steps the trigger block's channel index (histostosend) over
// all NCH channels. For each channel it waits SETTLE cycles for the
// registered histogram words to follow the index, then snapshots them. It
// then sends every word selected by the mask, MSB first, over a valid/ready
// byte port. The stream starts with a 0xA5 header byte. An optional 8-bit
// checksum byte follows the data.
//
// Optional feature macro: HISTO_READOUT_CKSUM_EN
//   defined   -> a trailing checksum byte (mod-256 sum of all data bytes)
//   undefined -> no checksum byte; the sum register is not built
//
// Ports:
//   clk_adc       in   single clock, rising edge
//   rst           in   synchronous active-high reset
//   start         in   one-cycle dump request, ignored unless idle
//   hist_mask     in   bit h selects histogram word h, sampled on start
//   histosin      in   NHIST x 32-bit words for the current index, word h at [32h+31:32h]
//   histostosend  out  channel index driven to the trigger block
//   tx_data       out  stream byte
//   tx_valid      out  tx_data valid
//   tx_ready      in   consumer accepts when tx_valid && tx_ready
//   busy          out  dump in progress
//   done          out  one-cycle pulse at end of dump

module histo_readout_seq #(
  parameter int NCH    = 16,
  parameter int NHIST  = 8,
  parameter int SETTLE = 3
) (
  input  logic                  clk_adc,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            hist_mask,
  input  logic [NHIST*32-1:0]   histosin,
  output logic [7:0]            histostosend,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int HW = $clog2(NHIST);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_SELECT, S_CAPTURE, S_SEND, S_NEXT, S_CKSUM, S_FIN
  } state_t;

  state_t          state, state_n;
  logic [7:0]      mask_r;
  logic [7:0]      ch;
  logic [3:0]      settle_cnt;
  logic [HW-1:0]   h;
  logic [1:0]      byte_idx;
  logic [31:0]     hist_buf [NHIST];
  logic [31:0]     cur_word;
  logic [7:0]      cur_byte;
  logic            first_found, next_found;
  logic [HW-1:0]   first_idx, next_idx;
  logic            last_ch;
`ifdef HISTO_READOUT_CKSUM_EN
  logic [7:0]      sum_r;
`endif

  assign last_ch = (ch == 8'(NCH - 1));

  // Lowest set mask bit (first word of a channel) and the lowest set bit
  // above the current word (next word of the same channel).
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = 0; i < NHIST; i++) begin
      if (!first_found && mask_r[i]) begin
        first_found = 1'b1;
        first_idx   = HW'(i);
      end
      if (!next_found && mask_r[i] && (i > int'(h))) begin
        next_found = 1'b1;
        next_idx   = HW'(i);
      end
    end
  end

  // Byte of the current word under the byte pointer, MSB first.
  always_comb begin
    cur_word = hist_buf[h];
    case (byte_idx)
      2'd0:    cur_byte = cur_word[31:24];
      2'd1:    cur_byte = cur_word[23:16];
      2'd2:    cur_byte = cur_word[15:8];
      default: cur_byte = cur_word[7:0];
    endcase
  end

  always_ff @(posedge clk_adc) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next state and stream outputs. tx_valid/tx_data derive only from
  // registered state, so they stay put while the consumer stalls.
  always_comb begin
    state_n  = state;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_n = S_HDR;
      end
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        if (tx_ready) state_n = S_SELECT;
      end
      S_SELECT: begin
        if (settle_cnt <= 4'd1) state_n = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_n = first_found ? S_SEND : S_CKSUM;
      end
      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = cur_byte;
        if (tx_ready && byte_idx == 2'd3 && !next_found) state_n = S_NEXT;
      end
      S_NEXT: begin
        state_n = last_ch ? S_CKSUM : S_SELECT;
      end
      S_CKSUM: begin
`ifdef HISTO_READOUT_CKSUM_EN
        tx_valid = 1'b1;
        tx_data  = sum_r;
        if (tx_ready) state_n = S_FIN;
`else
        state_n = S_FIN;
`endif
      end
      S_FIN: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Sequencer datapath. histostosend is only reloaded on entry to SELECT,
  // so it keeps the last channel after a dump.
  always_ff @(posedge clk_adc) begin
    if (rst) begin
      mask_r       <= '0;
      ch           <= '0;
      settle_cnt   <= '0;
      h            <= '0;
      byte_idx     <= '0;
      histostosend <= '0;
`ifdef HISTO_READOUT_CKSUM_EN
      sum_r        <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mask_r <= hist_mask;
            ch     <= '0;
`ifdef HISTO_READOUT_CKSUM_EN
            sum_r  <= '0;
`endif
          end
        end
        S_HDR: begin
          if (tx_ready) begin
            histostosend <= ch;
            settle_cnt   <= 4'(SETTLE);
          end
        end
        S_SELECT: begin
          settle_cnt <= settle_cnt - 4'd1;
        end
        S_CAPTURE: begin
          h        <= first_idx;
          byte_idx <= '0;
        end
        S_SEND: begin
          if (tx_ready) begin
`ifdef HISTO_READOUT_CKSUM_EN
            sum_r <= sum_r + cur_byte;
`endif
            if (byte_idx == 2'd3) begin
              byte_idx <= '0;
              h        <= next_idx;
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        S_NEXT: begin
          if (!last_ch) begin
            ch           <= ch + 8'd1;
            histostosend <= ch + 8'd1;
            settle_cnt   <= 4'(SETTLE);
          end
        end
        default: ;
      endcase
    end
  end

  // Snapshot of the settled histogram words for the current channel.
  always_ff @(posedge clk_adc) begin
    if (state == S_CAPTURE) begin
      for (int i = 0; i < NHIST; i++) hist_buf[i] <= histosin[32*i +: 32];
    end
  end

endmodule
